ahb_sram_sub: RTL and testbench
===============================

AHB_SRAM_SUB -- requirements
Module: ahb_sram_sub

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, HADDR width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, HRDATA/HWDATA width (32 or 64).
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of DATA_WIDTH words.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, HREADYOUT-low cycles inserted before each OKAY data-phase completion.
REQ-005 SHALL have ports:
- HCLK in 1: clock, rising edge.
- HRESETn in 1: asynchronous active-low reset.
- HSELx in 1: subordinate select.
- HADDR in ADDR_WIDTH: byte address.
- HTRANS in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE in 1: 1=write.
- HSIZE in 3: transfer size, log2 bytes.
- HBURST in 3: burst type, ignored.
- HPROT in 4: protection.
- HMASTLOCK in 1: lock, ignored.
- HWDATA in DATA_WIDTH: write data.
- HWSTRB in DATA_WIDTH/8: write byte strobes.
- HREADY in 1: bus-level ready.
- HRDATA out DATA_WIDTH: read data.
- HREADYOUT out 1: subordinate ready.
- HRESP out 1: 0=OKAY, 1=ERROR.

Function
REQ-006 SHALL accept an address phase only on a rising edge with HSELx=1, HREADY=1, HTRANS[1]=1, capturing HADDR, HWRITE, HSIZE and HPROT.
REQ-007 SHALL answer IDLE, BUSY or unselected cycles with HREADYOUT=1, HRESP=0 and zero wait states.
REQ-008 SHALL implement states IDLE, WAIT, DATA, ERR1, ERR2. Transitions: accepted OKAY transfer goes to WAIT if WAIT_STATES>0, otherwise DATA. WAIT goes to DATA after WAIT_STATES cycles. Accepted faulty transfer goes to ERR1. ERR1 goes to ERR2. DATA or ERR2 goes to IDLE, or directly starts the next accepted transfer.
REQ-009 SHALL drive HREADYOUT=0, HRESP=0 in WAIT; HREADYOUT=1, HRESP=0 in DATA; HREADYOUT=0, HRESP=1 in ERR1; HREADYOUT=1, HRESP=1 in ERR2.
REQ-010 SHALL flag a transfer faulty when any of these holds:
- word index HADDR/(DATA_WIDTH/8) >= MEM_DEPTH;
- HSIZE > log2(DATA_WIDTH/8);
- HADDR is not aligned to HSIZE.
REQ-011 SHALL, in the DATA cycle of a write, commit only bytes enabled by both HWSTRB and the HSIZE/HADDR lane mask.
REQ-012 SHALL, in the DATA cycle of a read, drive HRDATA from the array at the captured word index. The read is combinational on the captured address, so a write committed in the previous cycle is returned.
REQ-013 SHALL drive HRDATA=0 in all cycles other than a read DATA cycle.
REQ-014 SHALL never commit memory for a faulty transfer.
REQ-015 SHALL ignore address phases presented while its own HREADYOUT=0.
REQ-016 SHALL accept back-to-back transfers, with the DATA/ERR2 cycle overlapping the next address phase, with no added bubble.

Reset
REQ-017 SHALL, while HRESETn=0, force state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0 and clear all captured address-phase registers.
REQ-018 SHALL, on reset mid-transfer, discard the pending write; memory contents SHALL NOT be reset.

Configuration
REQ-019 SHALL, with AHB_SUB_PROT_CHECK_EN defined, also flag as faulty (ERROR per REQ-009) any write with HPROT[1]=0 (unprivileged).
REQ-020 SHALL, without AHB_SUB_PROT_CHECK_EN, ignore HPROT entirely.

Verification
REQ-021 WAIT_STATES=0, write word 0xDEADBEEF at 0x10, then read 0x10 -> read DATA cycle HRDATA=0xDEADBEEF, HRESP=0, no HREADYOUT low.
REQ-022 WAIT_STATES=2, read 0x04 -> HREADYOUT low for exactly 2 cycles, then high with data.
REQ-023 Write 0x000000AA, HSIZE=0, at 0x21 over word 0x11223344 -> read 0x20 returns 0x1122AA44.
REQ-024 MEM_DEPTH=256, read 0x400 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1); a following IDLE gets OKAY.
REQ-025 HSIZE=2 at 0x02 -> two-cycle ERROR; word at 0x00 unchanged.
REQ-026 Assert HRESETn=0 during a WAIT state of a write -> outputs at reset values immediately; target word unchanged.

Source files
------------

// File: rtl/ahb_sram_sub.sv
// ahb_sram_sub: AHB-Lite SRAM subordinate with a byte-strobed word array,
// programmable wait states before each OKAY completion and a two-cycle ERROR
// response for out-of-range, oversized or misaligned transfers.
// Optional feature: define AHB_SUB_PROT_CHECK_EN to also reject unprivileged
// writes (HPROT[1]=0) with an ERROR response.
module ahb_sram_sub #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSELx,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int SIZE_MAX = $clog2(BYTES);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [3:0]              r_waitCnt;
    logic [3:0]              w_nextWaitCnt;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [2:0]              r_size;
    logic [3:0]              r_prot;

    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_canAccept;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_wordAddr;
    logic                    w_outOfRange;
    logic                    w_tooBig;
    logic                    w_misaligned;
    logic                    w_protFault;
    logic                    w_fault;
    logic                    w_readyOut;
    logic                    w_resp;
    logic [IDX_W-1:0]        w_index;
    logic [SIZE_MAX-1:0]     w_offset;
    logic [BYTES-1:0]        w_byteEn;
    logic                    w_unused;

    // An address phase is only taken while this subordinate is itself ready,
    // i.e. in IDLE or in the last (ready-high) cycle of a DATA/ERR2 response.
    assign w_canAccept = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
    assign w_accept    = w_canAccept && HSELx && HREADY && HTRANS[1];

    // Fault classification of the address phase currently on the bus.
    assign w_wordAddr   = HADDR >> SIZE_MAX;
    assign w_outOfRange = (w_wordAddr >= ADDR_WIDTH'(MEM_DEPTH));
    assign w_tooBig     = (HSIZE > 3'(SIZE_MAX));

`ifdef AHB_SUB_PROT_CHECK_EN
    assign w_protFault = HWRITE && !HPROT[1];
`else
    assign w_protFault = 1'b0;
`endif

    assign w_fault = w_outOfRange || w_tooBig || w_misaligned || w_protFault;

    // Misaligned when any address bit below the transfer size is set; sizes
    // wider than the bus are already faulty, so only bus-width bits matter.
    always_comb begin
        w_misaligned = 1'b0;
        for (int i = 0; i < SIZE_MAX; i++) begin
            if ((3'(i) < HSIZE) && HADDR[i]) begin
                w_misaligned = 1'b1;
            end
        end
    end

    // Capture the accepted address phase for use in the following data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_prot  <= 4'd0;
        end else if (w_accept) begin
            r_addr  <= HADDR;
            r_write <= HWRITE;
            r_size  <= HSIZE;
            r_prot  <= HPROT;
        end
    end

    // Response state register and wait-state down-counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    // Next-state and bus-response decode; IDLE, DATA and ERR2 all end a
    // response with ready high, so each can launch the next transfer directly.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_readyOut    = 1'b1;
        w_resp        = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_readyOut = 1'b0;
                if (r_waitCnt == 4'd0) begin
                    w_nextState = S_DATA;
                end else begin
                    w_nextWaitCnt = r_waitCnt - 4'd1;
                end
            end
            S_ERR1: begin
                w_readyOut  = 1'b0;
                w_resp      = 1'b1;
                w_nextState = S_ERR2;
            end
            default: begin
                if (r_state == S_ERR2) begin
                    w_resp = 1'b1;
                end
                if (w_accept) begin
                    if (w_fault) begin
                        w_nextState = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_nextState   = S_WAIT;
                        w_nextWaitCnt = WAIT_LOAD;
                    end else begin
                        w_nextState = S_DATA;
                    end
                end else begin
                    w_nextState = S_IDLE;
                end
            end
        endcase
    end

    assign HREADYOUT = w_readyOut;
    assign HRESP     = w_resp;

    assign w_index  = r_addr[SIZE_MAX +: IDX_W];
    assign w_offset = r_addr[SIZE_MAX-1:0];

    // Byte lanes written in a write DATA cycle: inside the HSIZE/HADDR lane
    // window and also enabled by HWSTRB. Faulty transfers never reach DATA.
    always_comb begin
        w_byteEn = '0;
        for (int b = 0; b < BYTES; b++) begin
            if ((b >= int'(w_offset)) && (b < (int'(w_offset) + (1 << r_size))) && HWSTRB[b]) begin
                w_byteEn[b] = (r_state == S_DATA) && r_write;
            end
        end
    end

    // Memory array write port; contents deliberately survive reset.
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < BYTES; b++) begin
            if (w_byteEn[b]) begin
                r_mem[w_index][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
    end

    // Read data is combinational on the captured index and zero otherwise.
    assign HRDATA = ((r_state == S_DATA) && !r_write) ? r_mem[w_index] : '0;

    assign w_unused = &{1'b0, HBURST, HMASTLOCK, r_prot, r_addr};

endmodule

// File: tb/tb_ahb_sram_sub.sv
// tb_ahb_sram_sub: randomized self-checking bench for ahb_sram_sub. Two
// instances (WAIT_STATES 0 and 2) share the bus; only the active one is
// selected. A word-array reference model predicts faults, wait counts and
// read data from the transfer rules.
module tb_ahb_sram_sub;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [3:0]  prot;
    } xfer_t;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          busSel;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic          HMASTLOCK;
    logic [DW-1:0] HWDATA;
    logic [3:0]    HWSTRB;

    int            active;
    logic          sel0, sel1;
    logic          ready0, ready1, resp0, resp1;
    logic [DW-1:0] rdata0, rdata1;
    logic          busReady, busResp;
    logic [DW-1:0] busRdata;

    logic [31:0]   model [2][DEPTH];
    xfer_t         q[$];
    int            compared;
    int            mismatched;
    int            lastLows;
    logic          lastResp;
    logic [31:0]   lastRdata;
    logic [31:0]   saved;

    always #5 HCLK = ~HCLK;

    assign sel0     = busSel && (active == 0);
    assign sel1     = busSel && (active == 1);
    assign busReady = (active == 0) ? ready0 : ready1;
    assign busResp  = (active == 0) ? resp0 : resp1;
    assign busRdata = (active == 0) ? rdata0 : rdata1;

    ahb_sram_sub #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(busReady),
        .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
    );

    ahb_sram_sub #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(2)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(sel1), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(busReady),
        .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic xfer_t mk(input logic write, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        xfer_t x;
        x.sel   = 1'b1;
        x.trans = 2'b10;
        x.write = write;
        x.addr  = addr;
        x.size  = size;
        x.wdata = wdata;
        x.strb  = strb;
        x.prot  = 4'b0011;
        return x;
    endfunction

    function automatic xfer_t idleXfer();
        xfer_t x;
        x       = mk(1'b0, 32'd0, 3'd0, 32'd0, 4'd0);
        x.sel   = 1'b0;
        x.trans = 2'b00;
        return x;
    endfunction

    function automatic xfer_t randXfer();
        xfer_t x;
        int    r;
        x.sel   = ($urandom_range(0, 9) != 0);
        r       = int'($urandom_range(0, 9));
        x.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        x.write = 1'($urandom_range(0, 1));
        x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        x.addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 4095)) : 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) != 0) begin
            x.addr = x.addr & ~((32'd1 << x.size) - 32'd1);
        end
        x.wdata = $urandom;
        x.strb  = 4'($urandom_range(0, 15));
        x.prot  = 4'($urandom_range(0, 15));
        return x;
    endfunction

    function automatic bit isReal(input xfer_t x);
        return x.sel && x.trans[1];
    endfunction

    // Fault rules: beyond the array, wider than the bus, or not size-aligned.
    function automatic bit isFaulty(input xfer_t x);
        if ((x.addr / 4) >= DEPTH) return 1'b1;
        if (x.size > 3'd2) return 1'b1;
        if ((x.addr % (32'd1 << x.size)) != 0) return 1'b1;
`ifdef AHB_SUB_PROT_CHECK_EN
        if (x.write && !x.prot[1]) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // A byte changes when it lies in the addressed window and its strobe is set.
    function automatic logic [31:0] mergeWrite(input logic [31:0] old, input xfer_t x);
        logic [31:0] res;
        int          first;
        int          nbytes;
        res    = old;
        first  = int'(x.addr % 4);
        nbytes = 1 << x.size;
        for (int b = 0; b < 4; b++) begin
            if ((b >= first) && (b < first + nbytes) && x.strb[b]) begin
                res[b*8 +: 8] = x.wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Follows one data phase to completion, checking every stalled cycle and
    // the completing one, then applies an accepted write to the model.
    task automatic checkDataPhase(input xfer_t p);
        bit          f;
        bit          done;
        bit          lowBad;
        int          lows;
        int          expLows;
        int          idx;
        logic [31:0] expData;
        f       = isFaulty(p);
        expLows = f ? 1 : ((active == 0) ? 0 : 2);
        idx     = int'(p.addr >> 2);
        expData = (!f && !p.write) ? model[active][idx] : 32'd0;
        done    = 1'b0;
        lowBad  = 1'b0;
        lows    = 0;
        for (int c = 0; (c < 40) && !done; c++) begin
            @(negedge HCLK);
            if (busReady) begin
                done      = 1'b1;
                lastResp  = busResp;
                lastRdata = busRdata;
                checkOutput("respEnd", busResp, f);
                checkOutput("rdata", busRdata, expData);
                checkOutput("stallCycles", lows, expLows);
            end else begin
                lows++;
                if ((busResp !== f) || (busRdata !== 32'd0)) lowBad = 1'b1;
            end
            @(posedge HCLK);
            #1;
        end
        lastLows = lows;
        checkOutput("dataPhaseDone", done, 1);
        checkOutput("stallOutputs", lowBad, 0);
        if (done && !f && p.write) begin
            model[active][idx] = mergeWrite(model[active][idx], p);
        end
    endtask

    // Plays the queued transfers back-to-back, each address phase overlapping
    // the previous data phase, then drains with one idle cycle.
    task automatic applyStimulus();
        xfer_t cur;
        xfer_t prev;
        bit    havePrev;
        havePrev = 1'b0;
        prev     = idleXfer();
        for (int i = 0; i <= q.size(); i++) begin
            cur       = (i < q.size()) ? q[i] : idleXfer();
            busSel    = cur.sel;
            HADDR     = cur.addr;
            HTRANS    = cur.trans;
            HWRITE    = cur.write;
            HSIZE     = cur.size;
            HPROT     = cur.prot;
            HBURST    = 3'($urandom_range(0, 7));
            HMASTLOCK = 1'($urandom_range(0, 1));
            if (havePrev) begin
                HWDATA = prev.wdata;
                HWSTRB = prev.strb;
                checkDataPhase(prev);
            end else begin
                HWDATA = $urandom;
                HWSTRB = 4'($urandom_range(0, 15));
                @(negedge HCLK);
                checkOutput("idleReady", busReady, 1);
                checkOutput("idleResp", busResp, 0);
                checkOutput("idleRdata", busRdata, 0);
                @(posedge HCLK);
                #1;
            end
            havePrev = isReal(cur);
            prev     = cur;
        end
        q.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        active     = 0;
        lastLows   = 0;
        lastResp   = 1'b0;
        lastRdata  = 32'd0;
        busSel     = 1'b0;
        HADDR      = '0;
        HTRANS     = 2'b00;
        HWRITE     = 1'b0;
        HSIZE      = 3'd0;
        HBURST     = 3'd0;
        HPROT      = 4'd0;
        HMASTLOCK  = 1'b0;
        HWDATA     = '0;
        HWSTRB     = '0;
        HRESETn    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) model[d][w] = 32'd0;
        end

        $display("[TB] reset values");
        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("rstReady0", ready0, 1);
        checkOutput("rstResp0", resp0, 0);
        checkOutput("rstRdata0", rdata0, 0);
        checkOutput("rstReady1", ready1, 1);
        checkOutput("rstResp1", resp1, 0);
        checkOutput("rstRdata1", rdata1, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        $display("[TB] preload both arrays with back-to-back word writes");
        for (int d = 0; d < 2; d++) begin
            active = d;
            for (int w = 0; w < DEPTH; w++) q.push_back(mk(1'b1, 32'(w * 4), 3'd2, $urandom, 4'hF));
            applyStimulus();
        end

        $display("[TB] directed transfers, zero wait states");
        active = 0;
        q.push_back(mk(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF));
        q.push_back(mk(1'b0, 32'h10, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("wordReadBack", lastRdata, 32'hDEADBEEF);
        checkOutput("wordReadStalls", lastLows, 0);

        q.push_back(mk(1'b1, 32'h20, 3'd2, 32'h11223344, 4'hF));
        q.push_back(mk(1'b1, 32'h21, 3'd0, 32'hAAAAAAAA, 4'hF));
        q.push_back(mk(1'b0, 32'h20, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("byteMerge", lastRdata, 32'h1122AA44);

        q.push_back(mk(1'b0, 32'h400, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("rangeErrResp", lastResp, 1);
        checkOutput("rangeErrStalls", lastLows, 1);

        saved = model[0][0];
        q.push_back(mk(1'b1, 32'h02, 3'd2, ~saved, 4'hF));
        q.push_back(mk(1'b0, 32'h00, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("misalignNoWrite", lastRdata, saved);

        $display("[TB] directed transfers, two wait states");
        active = 1;
        q.push_back(mk(1'b0, 32'h04, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("waitStalls", lastLows, 2);
        checkOutput("waitRdata", lastRdata, model[1][1]);

        $display("[TB] reset during a write wait state");
        saved     = model[1][12];
        busSel    = 1'b1;
        HADDR     = 32'h30;
        HTRANS    = 2'b10;
        HWRITE    = 1'b1;
        HSIZE     = 3'd2;
        HPROT     = 4'b0011;
        @(posedge HCLK);
        #1;
        busSel    = 1'b0;
        HTRANS    = 2'b00;
        HWDATA    = ~saved;
        HWSTRB    = 4'hF;
        @(negedge HCLK);
        checkOutput("preResetStall", busReady, 0);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("asyncRstReady", busReady, 1);
        checkOutput("asyncRstResp", busResp, 0);
        checkOutput("asyncRstRdata", busRdata, 0);
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("heldRstReady", busReady, 1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        q.push_back(mk(1'b0, 32'h30, 3'd2, 32'd0, 4'h0));
        applyStimulus();
        checkOutput("rstWordKept", lastRdata, saved);

        $display("[TB] randomized traffic");
        for (int d = 0; d < 2; d++) begin
            active = d;
            for (int n = 0; n < 250; n++) q.push_back(randXfer());
            applyStimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
